// File: rtl/clocks_pkg.sv
// Shared constants for the board clock-divider bank.
// Default half-periods assume a 100 MHz master clock.
package clocks_pkg;

  localparam int CNT_W_DEF = 28;

  localparam logic MODE_SQUARE = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;

  localparam logic [CNT_W_DEF-1:0] HALF_FAST = 28'd500000;
  localparam logic [CNT_W_DEF-1:0] HALF_ADJ  = 28'd40000000;
  localparam logic [CNT_W_DEF-1:0] HALF_2HZ  = 28'd25000000;
  localparam logic [CNT_W_DEF-1:0] HALF_1HZ  = 28'd50000000;

  // ch0 sits in the least significant slice
  localparam logic [4*CNT_W_DEF-1:0] DEFAULT_HALF_BOARD =
    {HALF_1HZ, HALF_2HZ, HALF_ADJ, HALF_FAST};

endpackage

// File: rtl/div_channel.sv
// One divider channel: counter, programmable half-period and mode,
// registered square/pulse output and terminal-count tick.
module div_channel
  import clocks_pkg::*;
#(
  parameter int               CNT_W    = CNT_W_DEF,
  parameter logic [CNT_W-1:0] RST_HALF = '0
) (
  input  logic             master_clock,
  input  logic             rst_n,
  input  logic             load,
  input  logic             sync,
  input  logic             en,
  input  logic [CNT_W-1:0] half_in,
  input  logic             mode_in,
  output logic             clk_out,
  output logic             tick
);

  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] cnt;
  logic             mode;
  logic             term;

  assign term = (cnt == half - 1'b1);

  always_ff @(posedge master_clock) begin
    if (!rst_n) begin
      half    <= RST_HALF;
      mode    <= MODE_SQUARE;
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      if (load) begin
        half <= half_in;
        mode <= mode_in;
      end
      // a load or sync restarts the phase; half==0 parks the channel
      if (load || sync || half == '0) begin
        cnt     <= '0;
        clk_out <= 1'b0;
        tick    <= 1'b0;
      end else if (!en) begin
        tick <= 1'b0;
      end else if (term) begin
        cnt     <= '0;
        tick    <= 1'b1;
        clk_out <= (mode == MODE_PULSE) ? 1'b1 : ~clk_out;
      end else begin
        cnt  <= cnt + 1'b1;
        tick <= 1'b0;
        if (mode == MODE_PULSE) clk_out <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clock_divider_bank.sv
// Bank of NUM_CH programmable clock dividers with global phase sync
// and an error strobe for writes to channels that do not exist.
module clock_divider_bank
  import clocks_pkg::*;
#(
  parameter int                        NUM_CH       = 4,
  parameter int                        CNT_W        = CNT_W_DEF,
  parameter int                        CH_W         = 2,
  parameter logic [NUM_CH*CNT_W-1:0]   DEFAULT_HALF = DEFAULT_HALF_BOARD,
  parameter int                        SIM_DIV      = 1
) (
  input  logic              master_clock,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
  input  logic              cfg_mode,
  input  logic              sync,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic              cfg_err
);

  logic [NUM_CH-1:0] load;
  logic              bad_ch;

  // one extra bit so NUM_CH == 2**CH_W does not truncate to zero
  assign bad_ch = ({1'b0, cfg_ch} >= (CH_W+1)'(NUM_CH));

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [CNT_W-1:0] RH =
      CNT_W'(DEFAULT_HALF[i*CNT_W +: CNT_W] / SIM_DIV);

    assign load[i] = cfg_we && (cfg_ch == CH_W'(i));

    div_channel #(
      .CNT_W    (CNT_W),
      .RST_HALF (RH)
    ) u_ch (
      .master_clock (master_clock),
      .rst_n        (rst_n),
      .load         (load[i]),
      .sync         (sync),
      .en           (in_valid),
      .half_in      (cfg_half),
      .mode_in      (cfg_mode),
      .clk_out      (clk_out[i]),
      .tick         (tick[i])
    );
  end

  always_ff @(posedge master_clock) begin
    if (!rst_n) cfg_err <= 1'b0;
    else        cfg_err <= cfg_we && bad_ch;
  end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Self-checking bench for clock_divider_bank: per-cycle scoreboard
// against a behavioural model plus targeted timing checks.
module tb_clock_divider_bank;

  localparam int CW = 28;
  localparam logic [4*CW-1:0] DH =
    {28'd50000000, 28'd25000000, 28'd40000000, 28'd500000};

  logic          master_clock = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_ch = '0;
  logic [CW-1:0] cfg_half = '0;
  logic          cfg_mode = 1'b0;
  logic          sync = 1'b0;
  logic [3:0]    clk_out, tick;
  logic          cfg_err;
  logic [2:0]    clk_out2, tick2;
  logic          cfg_err2;

  int n_chk = 0;
  int n_pass = 0;

  logic [15:0] exp_q[$];

  logic [CW-1:0] m_half[4];
  logic [CW-1:0] m_cnt[4];
  logic          m_mode[4];
  logic [3:0]    m_out, m_tick;
  logic          m_err, m_err2;

  clock_divider_bank #(
    .NUM_CH(4), .CNT_W(CW), .CH_W(2),
    .DEFAULT_HALF(DH), .SIM_DIV(100)
  ) dut (
    .master_clock(master_clock), .rst_n(rst_n),
    .in_valid(in_valid), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_half(cfg_half), .cfg_mode(cfg_mode), .sync(sync),
    .clk_out(clk_out), .tick(tick), .cfg_err(cfg_err)
  );

  clock_divider_bank #(
    .NUM_CH(3), .CNT_W(CW), .CH_W(2),
    .DEFAULT_HALF(DH[3*CW-1:0]), .SIM_DIV(100)
  ) dut3 (
    .master_clock(master_clock), .rst_n(rst_n),
    .in_valid(in_valid), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_half(cfg_half), .cfg_mode(cfg_mode), .sync(sync),
    .clk_out(clk_out2), .tick(tick2), .cfg_err(cfg_err2)
  );

  always #5 master_clock = ~master_clock;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // expected state after the coming edge, from the current inputs
  task automatic model_step();
    logic [CW-1:0] defs[4];
    defs = '{28'd5000, 28'd400000, 28'd250000, 28'd500000};
    for (int i = 0; i < 4; i++) begin
      if (!rst_n) begin
        m_half[i] = defs[i]; m_mode[i] = 1'b0;
        m_cnt[i] = '0; m_out[i] = 1'b0; m_tick[i] = 1'b0;
      end else begin
        logic wr;
        wr = cfg_we && (int'(cfg_ch) == i);
        if (wr) begin
          m_half[i] = cfg_half; m_mode[i] = cfg_mode;
        end
        if (wr || sync || m_half[i] == 0 && !wr) begin
          m_cnt[i] = '0; m_out[i] = 1'b0; m_tick[i] = 1'b0;
        end else if (!in_valid) begin
          m_tick[i] = 1'b0;
        end else if (m_cnt[i] + 1 == m_half[i]) begin
          m_cnt[i] = '0; m_tick[i] = 1'b1;
          m_out[i] = m_mode[i] ? 1'b1 : !m_out[i];
        end else begin
          m_cnt[i] = m_cnt[i] + 1; m_tick[i] = 1'b0;
          if (m_mode[i]) m_out[i] = 1'b0;
        end
      end
    end
    m_err  = 1'b0;
    m_err2 = rst_n && cfg_we && cfg_ch == 2'd3;
  endtask

  task automatic cyc();
    logic [15:0] e, g;
    model_step();
    exp_q.push_back({m_out, m_tick, m_err, m_out[2:0], m_tick[2:0], m_err2});
    @(posedge master_clock);
    #1;
    e = exp_q.pop_front();
    g = {clk_out, tick, cfg_err, clk_out2, tick2, cfg_err2};
    chk("scoreboard", 32'(g), 32'(e));
  endtask

  task automatic wr(input logic [1:0] ch, input int half, input logic mode);
    cfg_we = 1'b1; cfg_ch = ch; cfg_half = CW'(half); cfg_mode = mode;
    cyc();
    cfg_we = 1'b0;
  endtask

  initial begin
    int n, first0, first1, errs;
    logic [8:0] tmask, kmask;
    logic prev, acc;

    cyc(); cyc();
    chk("reset_out", 32'({clk_out, tick, cfg_err}), 32'd0);
    rst_n = 1'b1; in_valid = 1'b1;

    n = 0;
    for (int k = 1; k <= 6000; k++) begin
      cyc();
      if (clk_out[0]) begin n = k; break; end
    end
    chk("ch0_first_rise", n, 5000);

    n = 0; prev = 1'b1;
    for (int k = 1; k <= 12000; k++) begin
      cyc();
      if (clk_out[0] && !prev) begin n = k; break; end
      prev = clk_out[0];
    end
    chk("ch0_period", n, 10000);

    in_valid = 1'b0;
    wr(2'd1, 3, 1'b0);
    in_valid = 1'b1;
    tmask = '0; kmask = '0; prev = clk_out[1];
    for (int k = 0; k < 9; k++) begin
      cyc();
      tmask[k] = clk_out[1] ^ prev; kmask[k] = tick[1];
      prev = clk_out[1];
    end
    chk("ch1_toggles", 32'(tmask), 32'b100100100);
    chk("ch1_ticks", 32'(kmask), 32'b100100100);

    wr(2'd1, 3, 1'b1);
    tmask = '0;
    for (int k = 0; k < 9; k++) begin
      cyc();
      tmask[k] = clk_out[1];
    end
    chk("ch1_pulse", 32'(tmask), 32'b100100100);

    in_valid = 1'b0;
    wr(2'd2, 4, 1'b0);
    in_valid = 1'b1;
    cyc(); cyc();
    in_valid = 1'b0; acc = 1'b0;
    for (int k = 0; k < 7; k++) begin
      cyc();
      acc = acc | clk_out[2] | (|tick);
    end
    chk("ch2_hold", 32'(acc), 32'd0);
    in_valid = 1'b1; n = 0;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (clk_out[2]) begin n = k; break; end
    end
    chk("ch2_resume", n, 2);

    in_valid = 1'b0;
    wr(2'd0, 5, 1'b0);
    wr(2'd1, 7, 1'b0);
    in_valid = 1'b1;
    cyc(); cyc(); cyc();
    sync = 1'b1;
    cyc();
    sync = 1'b0;
    chk("sync_clear", 32'({clk_out, tick}), 32'd0);
    first0 = 0; first1 = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (clk_out[0] && first0 == 0) first0 = k;
      if (clk_out[1] && first1 == 0) first1 = k;
    end
    chk("sync_ch0", first0, 5);
    chk("sync_ch1", first1, 7);

    wr(2'd3, 0, 1'b0);
    errs = int'(cfg_err2);
    acc = 1'b0;
    for (int k = 0; k < 100; k++) begin
      cyc();
      acc = acc | clk_out[3] | tick[3] | cfg_err;
      errs += int'(cfg_err2);
    end
    chk("ch3_off", 32'(acc), 32'd0);
    chk("err_pulses", errs, 1);

    wr(2'd1, 3, 1'b0);
    cyc(); cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("rst_mid", 32'({clk_out, tick}), 32'd0);
    acc = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      acc = acc | clk_out[1] | tick[1];
    end
    chk("rst_default", 32'(acc), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
